// File: rtl/riscv_mem_pkg.sv
// Shared funct3 encodings, error codes, FSM states and access legality check
// for the data-memory load/store unit.
package riscv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_MISALIGN = 2'd1,
    ERR_RANGE    = 2'd2,
    ERR_FN3      = 2'd3
  } lsu_err_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RESP    = 2'd2
  } lsu_state_e;

  // Priority: illegal funct3 over out-of-range over misaligned.
  function automatic lsu_err_e lsu_check(
    input logic       we,
    input logic [2:0] fn3,
    input logic [1:0] lane,
    input logic       in_range
  );
    logic legal;
    logic mis;
    if (we) legal = (fn3 == F3_B) || (fn3 == F3_H) || (fn3 == F3_W);
    else    legal = (fn3 == F3_B) || (fn3 == F3_H) || (fn3 == F3_W) ||
                    (fn3 == F3_BU) || (fn3 == F3_HU);
    if ((fn3 == F3_H) || (fn3 == F3_HU)) mis = lane[0];
    else if (fn3 == F3_W)                mis = (lane != 2'b00);
    else                                 mis = 1'b0;
    if (!legal)    return ERR_FN3;
    if (!in_range) return ERR_RANGE;
    if (mis)       return ERR_MISALIGN;
    return ERR_NONE;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte-enables/steered data and
// sub-word extraction with sign/zero extension for loads.
module lsu_align
  import riscv_mem_pkg::*;
(
  input  logic [2:0]  i_st_fn3,
  input  logic [1:0]  i_st_lane,
  input  logic [31:0] i_st_wdata,
  output logic [3:0]  o_be,
  output logic [31:0] o_wdata,
  input  logic [2:0]  i_ld_fn3,
  input  logic [1:0]  i_ld_lane,
  input  logic [31:0] i_ld_word,
  output logic [31:0] o_ld_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    o_be    = 4'b0000;
    o_wdata = 32'd0;
    case (i_st_fn3)
      F3_B: begin
        o_be    = 4'b0001 << i_st_lane;
        o_wdata = {4{i_st_wdata[7:0]}};
      end
      F3_H: begin
        o_be    = i_st_lane[1] ? 4'b1100 : 4'b0011;
        o_wdata = {2{i_st_wdata[15:0]}};
      end
      F3_W: begin
        o_be    = 4'b1111;
        o_wdata = i_st_wdata;
      end
      default: ;
    endcase
  end

  assign w_byte = i_ld_word[{i_ld_lane, 3'b000} +: 8];
  assign w_half = i_ld_lane[1] ? i_ld_word[31:16] : i_ld_word[15:0];

  always_comb begin
    o_ld_data = 32'd0;
    case (i_ld_fn3)
      F3_B:    o_ld_data = {{24{w_byte[7]}}, w_byte};
      F3_H:    o_ld_data = {{16{w_half[15]}}, w_half};
      F3_W:    o_ld_data = i_ld_word;
      F3_BU:   o_ld_data = {24'd0, w_byte};
      F3_HU:   o_ld_data = {16'd0, w_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_lsu_ctrl.sv
// Load/store unit and data-memory controller: valid/ready request, one
// outstanding access, configurable read latency and error responses.
module dmem_lsu_ctrl
  import riscv_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned RD_LATENCY  = 1,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_fn3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_err
);

  localparam int unsigned AW         = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN_BYTES = 33'(DEPTH_WORDS) * 33'd4;

  lsu_state_e  r_state, w_state_next;
  logic [2:0]  r_cnt, w_cnt_next;
  logic        r_we;
  logic [2:0]  r_fn3;
  logic [1:0]  r_lane;
  lsu_err_e    r_err;
  logic [31:0] r_hold_rdata;
  lsu_err_e    r_hold_err;

  logic        w_accept;
  logic        w_mem_en;
  logic [31:0] w_off;
  logic        w_in_range;
  logic [AW-1:0] w_idx;
  lsu_err_e    w_err;
  logic [3:0]  w_be;
  logic [31:0] w_st_data;
  logic [31:0] w_rd_word;
  logic [31:0] w_ld_data;
  logic [31:0] w_live_rdata;

  assign req_ready  = (r_state == IDLE);
  assign w_accept   = req_valid & req_ready & reset;
  assign w_off      = req_addr - BASE_ADDR;
  assign w_in_range = ({1'b0, w_off} < SPAN_BYTES);
  assign w_idx      = w_off[AW+1:2];
  assign w_err      = lsu_check(req_we, req_fn3, req_addr[1:0], w_in_range);
  assign w_mem_en   = w_accept && (w_err == ERR_NONE);

  lsu_align u_align (
    .i_st_fn3   (req_fn3),
    .i_st_lane  (req_addr[1:0]),
    .i_st_wdata (req_wdata),
    .o_be       (w_be),
    .o_wdata    (w_st_data),
    .i_ld_fn3   (r_fn3),
    .i_ld_lane  (r_lane),
    .i_ld_word  (w_rd_word),
    .o_ld_data  (w_ld_data)
  );

  // One byte-wide bank per lane so byte enables map onto independent RAMs.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      logic [7:0] r_bank [DEPTH_WORDS];
      logic [7:0] r_rd_byte;

      always_ff @(posedge clk) begin
        if (w_mem_en) begin
          if (req_we) begin
            if (w_be[gi]) r_bank[w_idx] <= w_st_data[8*gi +: 8];
          end else begin
            r_rd_byte <= r_bank[w_idx];
          end
        end
      end

      assign w_rd_word[8*gi +: 8] = r_rd_byte;
    end
  endgenerate

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if ((w_err != ERR_NONE) || req_we || (RD_LATENCY == 1)) begin
            w_state_next = RESP;
          end else begin
            w_state_next = RD_WAIT;
            w_cnt_next   = 3'(RD_LATENCY - 1);
          end
        end
      end
      RD_WAIT: begin
        if (r_cnt <= 3'd1) begin
          w_state_next = RESP;
          w_cnt_next   = 3'd0;
        end else begin
          w_cnt_next   = r_cnt - 3'd1;
        end
      end
      RESP:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_cnt        <= 3'd0;
      r_we         <= 1'b0;
      r_fn3        <= 3'd0;
      r_lane       <= 2'd0;
      r_err        <= ERR_NONE;
      r_hold_rdata <= 32'd0;
      r_hold_err   <= ERR_NONE;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_accept) begin
        r_we   <= req_we;
        r_fn3  <= req_fn3;
        r_lane <= req_addr[1:0];
        r_err  <= w_err;
      end
      // Latch the response as it leaves RESP so outputs stay stable until the next one.
      if (r_state == RESP) begin
        r_hold_rdata <= w_live_rdata;
        r_hold_err   <= r_err;
      end
    end
  end

  assign w_live_rdata = ((r_err == ERR_NONE) && !r_we) ? w_ld_data : 32'd0;
  assign rsp_valid    = (r_state == RESP);
  assign rsp_rdata    = rsp_valid ? w_live_rdata : r_hold_rdata;
  assign rsp_err      = rsp_valid ? r_err : r_hold_err;

endmodule
